// File: rtl/mem_arbiter_if.sv
// Bundle of core-side (fetch/data) and memory-side signals around mem_arbiter.
// slave is the arbiter's view; master is the view of the core/memory environment.
interface mem_arbiter_if;
  logic        i_start;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_rdata_valid;

  logic        d_cmd_start;
  logic        d_cmd_write;
  logic        d_cmd_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_wmask;
  logic [31:0] d_rdata;
  logic        d_rdata_valid;

  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;

  modport slave (
    input  i_start, i_addr,
    output i_ready, i_rdata, i_rdata_valid,
    input  d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
    output d_cmd_ready, d_rdata, d_rdata_valid,
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_cmd_ready, mem_rdata, mem_rdata_valid
  );

  modport master (
    output i_start, i_addr,
    input  i_ready, i_rdata, i_rdata_valid,
    output d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
    input  d_cmd_ready, d_rdata, d_rdata_valid,
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    output mem_cmd_ready, mem_rdata, mem_rdata_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one buffered command per side, one transaction at a time,
// at most one read in flight; data has priority, bounded by a fetch anti-starvation streak.
module mem_arbiter #(
  parameter int D_STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

  typedef enum logic {IDLE, WAIT_RD} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;

  logic          i_valid_q, i_valid_d;
  logic          i_busy_q, i_busy_d;
  logic [31:0]   i_addr_q, i_addr_d;

  logic          d_valid_q, d_valid_d;
  logic          d_busy_q, d_busy_d;
  logic          d_write_q, d_write_d;
  logic [31:0]   d_addr_q, d_addr_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  logic [31:0]   d_wmask_q, d_wmask_d;

  logic          i_accept, d_accept, pick_i;
  logic          mem_cmd_start, i_rdata_valid, d_rdata_valid;

  assign i_accept = bus.i_start && !i_busy_q;
  assign d_accept = bus.d_cmd_start && !d_busy_q;

  // Fetch wins only when data has nothing buffered or data has hit its streak limit.
  assign pick_i = i_valid_q && (!d_valid_q || (streak_q == STREAK_MAX));

  assign bus.i_ready       = !i_busy_q;
  assign bus.d_cmd_ready   = !d_busy_q;
  assign bus.i_rdata       = bus.mem_rdata;
  assign bus.d_rdata       = bus.mem_rdata;
  assign bus.i_rdata_valid = i_rdata_valid;
  assign bus.d_rdata_valid = d_rdata_valid;
  assign bus.mem_cmd_start = mem_cmd_start;
  assign bus.mem_addr      = pick_i ? i_addr_q : d_addr_q;
  assign bus.mem_cmd_write = !pick_i && d_write_q;
  assign bus.mem_wdata     = d_wdata_q;
  assign bus.mem_wmask     = d_wmask_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_d       = state_q;
    owner_d       = owner_q;
    streak_d      = streak_q;
    i_valid_d     = i_valid_q;
    i_busy_d      = i_busy_q;
    i_addr_d      = i_addr_q;
    d_valid_d     = d_valid_q;
    d_busy_d      = d_busy_q;
    d_write_d     = d_write_q;
    d_addr_d      = d_addr_q;
    d_wdata_d     = d_wdata_q;
    d_wmask_d     = d_wmask_q;
    mem_cmd_start = 1'b0;
    i_rdata_valid = 1'b0;
    d_rdata_valid = 1'b0;

    if (i_accept) begin
      i_valid_d = 1'b1;
      i_busy_d  = 1'b1;
      i_addr_d  = bus.i_addr;
    end
    if (d_accept) begin
      d_valid_d = 1'b1;
      d_busy_d  = 1'b1;
      d_write_d = bus.d_cmd_write;
      d_addr_d  = bus.d_addr;
      d_wdata_d = bus.d_wdata;
      d_wmask_d = bus.d_wmask;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.mem_cmd_ready && (i_valid_q || d_valid_q)) begin
          mem_cmd_start = 1'b1;
          if (pick_i) begin
            i_valid_d = 1'b0;
            owner_d   = OWN_I;
            state_d   = WAIT_RD;
            streak_d  = '0;
          end else begin
            d_valid_d = 1'b0;
            // A store completes on issue; only a load waits for read data.
            if (d_write_q) begin
              d_busy_d = 1'b0;
            end else begin
              owner_d = OWN_D;
              state_d = WAIT_RD;
            end
            if (i_valid_q && (streak_q != STREAK_MAX)) streak_d = streak_q + SW'(1);
          end
        end
      end
      WAIT_RD: begin
        if (bus.mem_rdata_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_I) begin
            i_rdata_valid = 1'b1;
            i_busy_d      = 1'b0;
          end else begin
            d_rdata_valid = 1'b1;
            d_busy_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_valid_q) streak_d = '0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      streak_q  <= '0;
      i_valid_q <= 1'b0;
      i_busy_q  <= 1'b0;
      d_valid_q <= 1'b0;
      d_busy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      i_valid_q <= i_valid_d;
      i_busy_q  <= i_busy_d;
      d_valid_q <= d_valid_d;
      d_busy_q  <= d_busy_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed behind their valid flags.
  always_ff @(posedge clk) begin
    i_addr_q  <= i_addr_d;
    d_write_q <= d_write_d;
    d_addr_q  <= d_addr_d;
    d_wdata_q <= d_wdata_d;
    d_wmask_q <= d_wmask_d;
  end

endmodule
